// File: rtl/uart_rx.sv
// Serial receiver: start bit, DATA_BITS data bits (LSB first), one stop bit, mid-bit sampling.
// Optional two-flop input synchronizer is enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
  parameter int BAUD_DIV  = int'(1e8 / 9600),
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], i_rx};
  // Flops reset high so the idle line is never mistaken for a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = i_rx;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 expire;

  // A load of N reaches 1 exactly N cycles later; that cycle is the sample point.
  assign expire = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_FULL;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
          else                              idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand sequences, checked through a pulse scoreboard.
module tb_uart_rx;
  localparam int B = 16;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = B/2 + 9*B + 1 + 2;
`else
  localparam int LAT = B/2 + 9*B + 1;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  uart_rx #(.BAUD_DIV(B), .DATA_BITS(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] data; logic err; int cyc;} exp_t;
  exp_t sb[$];

  typedef struct {logic [7:0] data; logic stop; int gap; logic exp_err; logic [7:0] exp_data;} vec_t;

  int checks = 0, passes = 0;
  logic [7:0] good_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Caller is at posedge+1; leaves at posedge+1 with the stop level still on the line.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic push);
    exp_t e;
    if (push) begin
      e.err  = ~stop;
      e.data = stop ? d : good_data;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
      if (stop) good_data = d;
    end
    i_rx = 1'b0;
    wait_cyc(B);
    for (int k = 0; k < 8; k++) begin
      i_rx = d[k];
      wait_cyc(B);
    end
    i_rx = stop;
    wait_cyc(B);
  endtask

  always @(negedge i_clk) begin
    if (!i_reset && (o_valid || o_frame_err)) begin
      chk("valid_err_exclusive", int'(o_valid & o_frame_err), 0);
      if (sb.size() == 0) begin
        chk("spurious_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_err", int'(o_frame_err), int'(e.err));
        chk("pulse_data", int'(o_data), int'(e.data));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  vec_t vecs[8];
  int   busy_cnt;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 20, 1'b0, 8'h5A};
    vecs[1] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 20, 1'b0, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 0,  1'b0, 8'h55};
    vecs[4] = '{8'hAA, 1'b1, 20, 1'b0, 8'hAA};
    vecs[5] = '{8'h01, 1'b1, 20, 1'b0, 8'h01};
    vecs[6] = '{8'hC3, 1'b0, 20, 1'b1, 8'h01};
    vecs[7] = '{8'h99, 1'b1, 20, 1'b0, 8'h99};

    repeat (3) @(negedge i_clk);
    chk("reset_data", int'(o_data), 0);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_ferr", int'(o_frame_err), 0);
    chk("reset_busy", int'(o_busy), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    wait_cyc(10);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b1);
      chk("table_exp_data", int'(vecs[i].stop ? vecs[i].data : good_data), int'(vecs[i].exp_data));
      if (vecs[i].gap > 0) begin
        i_rx = 1'b1;
        wait_cyc(vecs[i].gap);
      end
    end

    // False start: 4-cycle glitch must be rejected after half a bit of busy.
    busy_cnt = 0;
    i_rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (o_busy) busy_cnt++;
      @(posedge i_clk); #1;
      if (i == 3) i_rx = 1'b1;
    end
    chk("glitch_busy_cycles", busy_cnt, B/2);
    chk("glitch_busy_end", int'(o_busy), 0);
    send_frame(8'hA5, 1'b1, 1'b1);
    i_rx = 1'b1;
    wait_cyc(20);

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_cyc(500);
    chk("break_busy", int'(o_busy), 1);
    chk("break_data_kept", int'(o_data), 8'hA5);
    i_rx = 1'b1;
    wait_cyc(20);
    chk("break_exit_busy", int'(o_busy), 0);
    send_frame(8'h81, 1'b1, 1'b1);
    i_rx = 1'b1;
    wait_cyc(20);

    // Asynchronous reset during data bit 3 of an unscored frame.
    i_rx = 1'b0;
    wait_cyc(B*4 + 5);
    chk("pre_reset_busy", int'(o_busy), 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("midreset_busy", int'(o_busy), 0);
    chk("midreset_data", int'(o_data), 0);
    chk("midreset_valid", int'(o_valid), 0);
    chk("midreset_ferr", int'(o_frame_err), 0);
    i_rx = 1'b1;
    good_data = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    wait_cyc(20);
    send_frame(8'h7E, 1'b1, 1'b1);
    i_rx = 1'b1;

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge i_clk);
    wait_cyc(5);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_data", int'(o_data), 8'h7E);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side companion of the team's UART transmitter. It recovers 8N1-style frames from a single line: one start bit (0), DATA_BITS data bits LSB first, and one stop bit (1). It presents each received word as a one-cycle valid pulse and flags framing errors. It sits between a pad/input pin and the on-chip consumer, such as a command decoder or FIFO. Baud timing comes from an internal down-counter running from the system clock.

## Interface
Parameters:
- BAUD_DIV, default int'(1e8 / 9600): clock cycles per bit; must be >= 4.
- DATA_BITS, default 8: data bits per frame; range 5–9.

Ports (one clock; reset is asynchronous and active-high):
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous active-high reset.
- i_rx  input  1  serial line; idles high.
- o_data  output  DATA_BITS  last good received word, LSB = first bit on the line; held until the next good frame.
- o_valid  output  1  one-cycle pulse; o_data is new this cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- o_busy  output  1  high in every state except IDLE.

## Operation
- rx_s is the line as seen by the FSM: the synchronized i_rx (see Configuration).
- **States**
  - **IDLE:** while rx_s == 1, wait. On the first cycle with rx_s == 0, load the counter with BAUD_DIV/2 (floor) and go to START.
  - **START:** when the counter expires, sample rx_s.
    - If rx_s == 1, this is a glitch/false start: return to IDLE with no output pulse.
    - If rx_s == 0, load BAUD_DIV, clear the bit index, and go to DATA.
  - **DATA:** at each counter expiry, shift rx_s into the MSB of the shift register (right shift) and reload BAUD_DIV. After DATA_BITS samples, go to STOP.
  - **STOP:** at counter expiry, sample rx_s.
    - If rx_s == 1, register the shift register into o_data, pulse o_valid, and go to IDLE.
    - If rx_s == 0, pulse o_frame_err, leave o_data unchanged, and go to BREAK.
  - **BREAK:** wait until rx_s == 1, then go to IDLE. A line held low (break condition) therefore yields exactly one o_frame_err and no spurious frames.
- **Counter:** width $clog2(BAUD_DIV+1). "Expiry" means the counter reaches 1 after being loaded with N, i.e. N cycles after the load.
- **Outputs:** o_valid and o_frame_err are never high in the same cycle.
- **Reset:** i_reset asserted at any time, including mid-frame, forces IDLE immediately. A partial frame is discarded with no pulse.

## Timing
- Let T be the cycle in which IDLE first sees rx_s == 0.
- Start bit is sampled at T + BAUD_DIV/2.
- Data bit k (k = 0..DATA_BITS-1) is sampled at T + BAUD_DIV/2 + (k+1)·BAUD_DIV.
- Stop bit is sampled at S = T + BAUD_DIV/2 + (DATA_BITS+1)·BAUD_DIV.
- o_valid / o_frame_err are high in cycle S+1. The FSM is in IDLE at S+1, so a start edge at S+1 is accepted (back-to-back frames).
- o_busy rises at T+1 and falls at S+1 (good frame), or one cycle after rx_s returns high (BREAK).
- Reset values: o_data = 0, o_valid = 0, o_frame_err = 0, o_busy = 0, state IDLE, synchronizer flops = 1.
- Sampling at mid-bit tolerates ±(BAUD_DIV/2 − 1) cycles of accumulated skew per frame.

## Configuration
- Macro: UART_RX_SYNC_EN.
- **Defined:** i_rx passes through a two-flop synchronizer (both flops reset to 1) before use. rx_s lags i_rx by 2 cycles, so T is 2 cycles after the line edge reaches i_rx. i_rx may be fully asynchronous.
- **Undefined:** rx_s = i_rx directly, with no added latency. The caller guarantees i_rx is synchronous to i_clk.

## Test plan
- **Good frame:** BAUD_DIV=16, DATA_BITS=8; drive 0x5A, LSB first, with a stop bit → o_data=0x5A and a single o_valid pulse at S+1; o_frame_err stays 0.
- **Back-to-back:** drive 0x00 then 0xFF with no idle gap between frames → two o_valid pulses exactly (DATA_BITS+2)·16 = 160 cycles apart, carrying 0x00 then 0xFF.
- **False start:** drive a 4-cycle low glitch on an idle line → no pulse; o_busy high for 8 cycles then low; a following good frame (0xA5) is received correctly.
- **Framing error and break:** drive 0x3C with stop bit = 0, then hold the line low for 500 cycles → one o_frame_err pulse, no o_valid, o_data keeps its previous value; after the line goes high, a good frame 0x81 is received.
- **Reset mid-frame:** assert i_reset asynchronously during data bit 3 → o_busy=0 and all outputs at reset values immediately; a subsequent frame 0x7E is received correctly.
- **Configuration check:** run the good-frame test with and without UART_RX_SYNC_EN → o_valid timing differs by exactly 2 cycles; data is identical.
